// File: rtl/imem_server.sv
// imem_server: dual-word instruction memory with a byte-stream program loader.
// Ports: clk, rstn (sync, active-low); raddr -> rdata/rdata1 (word, word+1, 1-cycle);
//        ld_valid/ld_data/ld_ready byte handshake; ld_done (sticky), ld_words (count).
module imem_server #(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [31:0]   raddr,
    output logic [31:0]   rdata,
    output logic [31:0]   rdata1,
    input  logic          ld_valid,
    input  logic [7:0]    ld_data,
    output logic          ld_ready,
    output logic          ld_done,
    output logic [AW:0]   ld_words
);

    localparam int HD = 2 ** (AW - 1);

    typedef enum logic [1:0] {
        S_LEN,
        S_DATA,
        S_DONE
    } state_e;

    // Even/odd banks: word i lives in bank i[0] at row i[AW-1:1].
    logic [31:0] mem_e [HD];
    logic [31:0] mem_o [HD];

    logic [AW-1:0] widx;
    logic [AW-1:0] widx1;
    logic [AW-2:0] ea;
    logic [AW-2:0] oa;
    logic [31:0]   e_q;
    logic [31:0]   o_q;
    logic          sel_q;
    logic          unused_addr;

    assign widx  = raddr[AW+1:2];
    assign widx1 = widx + AW'(1);
    // For an odd widx the following word is in the even bank, one row up.
    assign ea    = widx[0] ? widx1[AW-1:1] : widx[AW-1:1];
    assign oa    = widx[AW-1:1];
    assign unused_addr = ^{raddr[31:AW+2], raddr[1:0]};

    // Loader state
    state_e        state_q, state_d;
    logic [1:0]    bcnt_q, bcnt_d;
    logic [23:0]   sh_q, sh_d;
    logic [31:0]   len_q, len_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [31:0]   wcnt_q, wcnt_d;
    logic [AW:0]   words_q, words_d;
    logic          we;
    logic          acc;
    logic [31:0]   word;

    assign ld_ready = (state_q != S_DONE);
    assign ld_done  = (state_q == S_DONE);
    assign ld_words = words_q;
    assign acc      = ld_valid && ld_ready;
    assign word     = {ld_data, sh_q};

    // Read port; the non-blocking update gives read-first on collision.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            e_q   <= '0;
            o_q   <= '0;
            sel_q <= 1'b0;
        end else begin
            e_q   <= mem_e[ea];
            o_q   <= mem_o[oa];
            sel_q <= widx[0];
        end
    end

    assign rdata  = sel_q ? o_q : e_q;
    assign rdata1 = sel_q ? e_q : o_q;

    // Write port; blocked during reset so a stale DATA state cannot write.
    always_ff @(posedge clk) begin
        if (we && rstn) begin
            if (wptr_q[0]) begin
                mem_o[wptr_q[AW-1:1]] <= word;
            end else begin
                mem_e[wptr_q[AW-1:1]] <= word;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= S_LEN;
            bcnt_q  <= '0;
            sh_q    <= '0;
            len_q   <= '0;
            wptr_q  <= '0;
            wcnt_q  <= '0;
            words_q <= '0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            sh_q    <= sh_d;
            len_q   <= len_d;
            wptr_q  <= wptr_d;
            wcnt_q  <= wcnt_d;
            words_q <= words_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        sh_d    = sh_q;
        len_d   = len_q;
        wptr_d  = wptr_q;
        wcnt_d  = wcnt_q;
        words_d = words_q;
        we      = 1'b0;
        unique case (state_q)
            S_LEN: begin
                if (acc) begin
                    bcnt_d = bcnt_q + 2'd1;
                    sh_d   = {ld_data, sh_q[23:8]};
                    if (bcnt_q == 2'd3) begin
                        len_d   = word;
                        wptr_d  = '0;
                        wcnt_d  = '0;
                        state_d = (word == 32'd0) ? S_DONE : S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (acc) begin
                    bcnt_d = bcnt_q + 2'd1;
                    sh_d   = {ld_data, sh_q[23:8]};
                    if (bcnt_q == 2'd3) begin
                        we     = 1'b1;
                        wptr_d = wptr_q + AW'(1);
                        wcnt_d = wcnt_q + 32'd1;
                        if (words_q != '1) begin
                            words_d = words_q + (AW+1)'(1);
                        end
                        if (wcnt_d == len_q) begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_DONE: begin
            end
            default: state_d = S_LEN;
        endcase
    end

endmodule

// File: tb/tb_imem_server.sv
// tb_imem_server: directed self-checking bench for imem_server.
// Drives loader bytes and fetch addresses; checks against hand-computed words.
module tb_imem_server;

    localparam int AW = 12;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] raddr;
    logic [31:0] rdata;
    logic [31:0] rdata1;
    logic        ld_valid;
    logic [7:0]  ld_data;
    logic        ld_ready;
    logic        ld_done;
    logic [AW:0] ld_words;

    int pass_cnt = 0;
    int total    = 0;

    imem_server #(.AW(AW)) dut (
        .clk(clk),
        .rstn(rstn),
        .raddr(raddr),
        .rdata(rdata),
        .rdata1(rdata1),
        .ld_valid(ld_valid),
        .ld_data(ld_data),
        .ld_ready(ld_ready),
        .ld_done(ld_done),
        .ld_words(ld_words)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        ld_valid = 1'b1;
        ld_data  = b;
        tick();
        ld_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        rstn     = 1'b0;
        ld_valid = 1'b1;
        ld_data  = 8'hAA;
        raddr    = 32'h0;
        tick();
        tick();
        total++;
        if (rdata !== 32'h0) $display("FAIL reset_rdata got %h want 0", rdata);
        else pass_cnt++;
        total++;
        if (rdata1 !== 32'h0) $display("FAIL reset_rdata1 got %h want 0", rdata1);
        else pass_cnt++;
        total++;
        if (ld_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", ld_ready);
        else pass_cnt++;
        total++;
        if (ld_done !== 1'b0) $display("FAIL reset_done got %b want 0", ld_done);
        else pass_cnt++;
        total++;
        if (ld_words !== '0) $display("FAIL reset_words got %0d want 0", ld_words);
        else pass_cnt++;
        ld_valid = 1'b0;
        rstn     = 1'b1;
    endtask

    task automatic test_load3();
        logic [7:0] bytes [16];
        bytes = '{8'h03, 8'h00, 8'h00, 8'h00,
                  8'h13, 8'h00, 8'h00, 8'h00,
                  8'h93, 8'h00, 8'h10, 8'h00,
                  8'h6F, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 16; i++) begin
            send(bytes[i]);
            if (i % 4 == 3) begin
                total++;
                if (ld_words !== (AW+1)'(i / 4))
                    $display("FAIL load3_words[%0d] got %0d want %0d",
                             i, ld_words, i / 4);
                else pass_cnt++;
                total++;
                if (ld_done !== (i == 15))
                    $display("FAIL load3_done[%0d] got %b want %b",
                             i, ld_done, i == 15);
                else pass_cnt++;
            end
        end
        total++;
        if (ld_ready !== 1'b0) $display("FAIL load3_ready got %b want 0", ld_ready);
        else pass_cnt++;
        send(8'h55);
        total++;
        if (ld_words !== (AW+1)'(3))
            $display("FAIL load3_ignore got %0d want 3", ld_words);
        else pass_cnt++;
    endtask

    task automatic test_read();
        raddr = 32'h4;
        tick();
        total++;
        if (rdata !== 32'h00100093) $display("FAIL rd4_rdata got %h want 00100093", rdata);
        else pass_cnt++;
        total++;
        if (rdata1 !== 32'h0000006F) $display("FAIL rd4_rdata1 got %h want 0000006f", rdata1);
        else pass_cnt++;
        raddr = 32'h6;
        tick();
        total++;
        if (rdata !== 32'h00100093) $display("FAIL rd6_rdata got %h want 00100093", rdata);
        else pass_cnt++;
        total++;
        if (rdata1 !== 32'h0000006F) $display("FAIL rd6_rdata1 got %h want 0000006f", rdata1);
        else pass_cnt++;
        raddr = 32'h0;
        tick();
        total++;
        if (rdata1 !== 32'h00100093) $display("FAIL rd0_rdata1 got %h want 00100093", rdata1);
        else pass_cnt++;
        raddr = 32'(4 * (2 ** AW - 1));
        tick();
        total++;
        if (rdata1 !== 32'h00000013) $display("FAIL rdwrap_rdata1 got %h want 00000013", rdata1);
        else pass_cnt++;
        raddr = 32'h8000_0008;
        tick();
        total++;
        if (rdata !== 32'h0000006F) $display("FAIL rdalias_rdata got %h want 0000006f", rdata);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [3];
        logic [31:0] exp [3];
        addrs = '{32'h0, 32'h8, 32'h4};
        exp   = '{32'h00000013, 32'h0000006F, 32'h00100093};
        for (int i = 0; i < 3; i++) begin
            raddr = addrs[i];
            tick();
            total++;
            if (rdata !== exp[i])
                $display("FAIL b2b[%0d] got %h want %h", i, rdata, exp[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_gapped();
        logic [7:0] bytes [8];
        bytes = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        pulse_reset();
        for (int i = 0; i < 8; i++) begin
            send(bytes[i]);
            if (i == 6) begin
                total++;
                if (ld_done !== 1'b0 || ld_words !== '0)
                    $display("FAIL gap_early got done=%b words=%0d want 0/0",
                             ld_done, ld_words);
                else pass_cnt++;
            end
            if (i < 7) tick();
        end
        total++;
        if (ld_done !== 1'b1) $display("FAIL gap_done got %b want 1", ld_done);
        else pass_cnt++;
        total++;
        if (ld_words !== (AW+1)'(1)) $display("FAIL gap_words got %0d want 1", ld_words);
        else pass_cnt++;
        raddr = 32'h0;
        tick();
        total++;
        if (rdata !== 32'hDEADBEEF) $display("FAIL gap_mem0 got %h want deadbeef", rdata);
        else pass_cnt++;
        total++;
        if (rdata1 !== 32'h00100093) $display("FAIL gap_keep1 got %h want 00100093", rdata1);
        else pass_cnt++;
    endtask

    task automatic test_len0();
        pulse_reset();
        for (int i = 0; i < 4; i++) send(8'h00);
        total++;
        if (ld_done !== 1'b1) $display("FAIL len0_done got %b want 1", ld_done);
        else pass_cnt++;
        total++;
        if (ld_words !== '0) $display("FAIL len0_words got %0d want 0", ld_words);
        else pass_cnt++;
        total++;
        if (ld_ready !== 1'b0) $display("FAIL len0_ready got %b want 0", ld_ready);
        else pass_cnt++;
        raddr = 32'h0;
        tick();
        total++;
        if (rdata !== 32'hDEADBEEF) $display("FAIL len0_mem0 got %h want deadbeef", rdata);
        else pass_cnt++;
    endtask

    task automatic test_reset_partial();
        logic [7:0] bytes [8];
        pulse_reset();
        send(8'h01); send(8'h00); send(8'h00); send(8'h00);
        send(8'hAA); send(8'hBB);
        pulse_reset();
        total++;
        if (ld_words !== '0 || ld_done !== 1'b0)
            $display("FAIL partial_rst got words=%0d done=%b want 0/0", ld_words, ld_done);
        else pass_cnt++;
        bytes = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11};
        for (int i = 0; i < 8; i++) send(bytes[i]);
        total++;
        if (ld_done !== 1'b1 || ld_words !== (AW+1)'(1))
            $display("FAIL partial_load got done=%b words=%0d want 1/1", ld_done, ld_words);
        else pass_cnt++;
        raddr = 32'h0;
        tick();
        total++;
        if (rdata !== 32'h11223344) $display("FAIL partial_mem0 got %h want 11223344", rdata);
        else pass_cnt++;
    endtask

    task automatic test_collision();
        pulse_reset();
        raddr = 32'h0;
        send(8'h01); send(8'h00); send(8'h00); send(8'h00);
        send(8'h55); send(8'h66); send(8'h77);
        send(8'h88);
        total++;
        if (rdata !== 32'h11223344) $display("FAIL coll_old got %h want 11223344", rdata);
        else pass_cnt++;
        tick();
        total++;
        if (rdata !== 32'h88776655) $display("FAIL coll_new got %h want 88776655", rdata);
        else pass_cnt++;
        total++;
        if (ld_done !== 1'b1) $display("FAIL coll_done got %b want 1", ld_done);
        else pass_cnt++;
    endtask

    initial begin
        rstn     = 1'b0;
        raddr    = 32'h0;
        ld_valid = 1'b0;
        ld_data  = 8'h0;
        test_reset();
        test_load3();
        test_read();
        test_back_to_back();
        test_gapped();
        test_len0();
        test_reset_partial();
        test_collision();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/imem_server.md
Name: imem_server

Overview:
- Instruction-memory responder for the fetch stage.
- Serves a synchronous dual-word read: the word at the requested address and the following word, one cycle later. The second word supports 64-bit instructions.
- Contains a byte-stream program loader, fed from the UART receive path, which fills the memory before the core is released.
- The loader's `ld_done` signal gates the core's enable.

Parameters:
- AW, 12, word-address width; memory depth = 2**AW 32-bit words.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- raddr  in  32  byte address from fetch; bits [1:0] ignored
- rdata  out  32  word at raddr, registered
- rdata1  out  32  word at raddr+4, registered
- ld_valid  in  1  loader byte valid
- ld_data  in  8  loader byte
- ld_ready  out  1  loader accepts a byte this cycle
- ld_done  out  1  program fully loaded, sticky
- ld_words  out  AW+1  number of words written so far

Behaviour:
- Word index: `widx = raddr[AW+1:2]`. Upper address bits above AW+1 are ignored, so addresses alias modulo the depth.
- Read latency is exactly 1 cycle. At posedge:
  - `rdata <= mem[widx]`
  - `rdata1 <= mem[(widx+1) mod 2**AW]`
  - At the last word, rdata1 wraps to `mem[0]`.
- Reads are issued every cycle; there is no read enable or stall input. Fetch holds raddr itself to stall.
- Read/write collision on the same index in the same cycle: read-first. The old word is returned; the new word is visible from the next read.
- Reset, while rstn is low at posedge:
  - rdata = 0, rdata1 = 0, ld_words = 0, ld_done = 0.
  - The loader FSM returns to LEN with the byte counter at 0.
  - Memory contents are NOT cleared.
- Loader handshake:
  - A byte transfers on a posedge where `ld_valid && ld_ready`.
  - ld_ready is high in LEN and DATA and low in DONE.
  - ld_ready is combinational from the state only; it does not depend on ld_valid.
  - Bytes are assembled little-endian: the first byte goes to [7:0], the fourth to [31:24].
- FSM states: LEN, DATA, DONE.
  - LEN:
    - Accept 4 bytes into a 32-bit length register N (word count). A 2-bit byte counter wraps at 4.
    - On the 4th byte: if N == 0, go to DONE; else go to DATA with write pointer wptr = 0.
  - DATA:
    - Accept bytes; on each 4th byte, write the assembled word to `mem[wptr]`, then wptr += 1 and ld_words += 1.
    - When ld_words reaches N after that write, go to DONE.
    - wptr wraps modulo 2**AW, so N > depth overwrites from index 0.
    - ld_words counts transfers (saturating at 2**(AW+1)-1) while N is compared against a full 32-bit word counter internally.
  - DONE:
    - ld_done = 1, registered: it asserts the cycle after the final write.
    - Further ld_valid is ignored.
    - The FSM is left only by reset.
- Gaps in ld_valid stall the FSM with no state change; a partial word is held indefinitely.
- Reset mid-load discards the partial word and the length. Already-written words remain in memory.
- Reads during loading are legal and return current memory contents. The core is expected to be held by ld_done, and this block does not enforce it.
- A single write port and two read ports are required. Implement as two BRAM copies written identically, or as an even/odd word bank split (preferred).
  - Even/odd split: the bank holding widx+1 is selected by widx[0].
  - The output mux select is registered so the 1-cycle latency holds.

Test Plan:
- Reset: hold rstn=0 for 2 cycles with ld_valid=1 → rdata=rdata1=0, ld_ready=1, ld_done=0, ld_words=0, no write occurs.
- Load N=3:
  - Stimulus: bytes 03 00 00 00, then 13 00 00 00, 93 00 10 00, 6F 00 00 00.
  - Response: mem[0..2] = 0x00000013, 0x00100093, 0x0000006F; ld_words steps 1, 2, 3; ld_done=1 one cycle after the last byte; ld_ready=0 thereafter.
- Read after load:
  - raddr=0x4 → next cycle rdata=0x00100093, rdata1=0x0000006F.
  - raddr=0x6 → same result (low bits ignored).
  - raddr=4*(2**AW-1) → rdata1 = mem[0] (wrap).
- Back-to-back reads: raddr 0x0, 0x8, 0x4 on consecutive cycles → rdata 0x13, 0x6F, 0x00100093 on the following consecutive cycles, with no bubble.
- Gapped loader: ld_valid toggled every other cycle while loading N=1 word 0xDEADBEEF (bytes EF BE AD DE) → same result as the ungapped case; mem[0]=0xDEADBEEF, ld_done after the 8th accepted byte.
- Edge cases:
  - N=0 → DONE after 4 bytes, ld_words=0.
  - Reset after 2 bytes of a data word, then reload N=1 with word 0x11223344 → mem[0]=0x11223344, and the stale partial bytes are not used.
  - Collision: read of index 0 in the same cycle as its write → the old value is returned, and the new value on the next read.
